// File: rtl/ark_word_sequencer.sv
// AddRoundKey sequencer: streams a captured state and round key one word per cycle
// through an external XOR unit and reassembles the results into state_out.
module ark_word_sequencer #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [WORD_W*NWORDS-1:0] state_in,
  input  logic [WORD_W*NWORDS-1:0] key_in,
  output logic [WORD_W-1:0]        xor_a,
  output logic [WORD_W-1:0]        xor_b,
  input  logic [WORD_W-1:0]        xor_y,
  output logic                     busy,
  output logic                     done,
  output logic [WORD_W*NWORDS-1:0] state_out
);

  localparam int            CW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t                          fsm;
  logic [CW-1:0]                 cnt;
  logic [CW-1:0]                 widx;
  // Element NWORDS-1 holds the MSBs, so AES word 0 lives at the top index.
  logic [NWORDS-1:0][WORD_W-1:0] st_q;
  logic [NWORDS-1:0][WORD_W-1:0] key_q;
  logic [NWORDS-1:0][WORD_W-1:0] res_q;

  assign widx      = LAST - cnt;
  assign state_out = res_q;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    xor_a = '0;
    xor_b = '0;
    if (fsm == RUN) begin
      xor_a = st_q[widx];
      xor_b = key_q[widx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm   <= IDLE;
      cnt   <= '0;
      st_q  <= '0;
      key_q <= '0;
      res_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start) begin
            st_q  <= state_in;
            key_q <= key_in;
            res_q <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            fsm   <= RUN;
          end
        end
        RUN: begin
          res_q[widx] <= xor_y;
          if (cnt == LAST) begin
            cnt  <= '0;
            done <= 1'b1;
            fsm  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          fsm  <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ark_word_sequencer.sv
// Bench for ark_word_sequencer: vector table, hand-written corner sequences and a
// random run, all scored against a cycle-level reference model and result queue.
module tb_ark_word_sequencer;

  localparam int NW = 4;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [127:0]  state_in;
  logic [127:0]  key_in;
  logic [31:0]   xor_a;
  logic [31:0]   xor_b;
  logic [31:0]   xor_y;
  logic          busy;
  logic          done;
  logic [127:0]  state_out;

  ark_word_sequencer #(.WORD_W(WW), .NWORDS(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .state_in  (state_in),
    .key_in    (key_in),
    .xor_a     (xor_a),
    .xor_b     (xor_b),
    .xor_y     (xor_y),
    .busy      (busy),
    .done      (done),
    .state_out (state_out)
  );

  // The shared XOR unit that sits outside the sequencer.
  assign xor_y = xor_a ^ xor_b;

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1..NW run word phase-1, NW+1 done.
  int           m_phase = 0;
  int           m_acc   = 0;
  int           n_done  = 0;
  logic [127:0] m_st;
  logic [127:0] m_key;
  logic [127:0] sb_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      sb_q.delete();
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase <= 1;
        m_st    <= state_in;
        m_key   <= key_in;
        m_acc   <= m_acc + 1;
        sb_q.push_back(state_in ^ key_in);
      end
    end else if (m_phase == NW + 1) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  function automatic logic [31:0] word_of(input logic [127:0] v, input int i);
    return 32'(v >> (32 * (NW - 1 - i)));
  endfunction

  logic [31:0]  ea, eb;
  logic [127:0] eres;

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", busy, m_phase != 0);
      check("done", done, m_phase == NW + 1);
      ea = '0;
      eb = '0;
      if (m_phase >= 1 && m_phase <= NW) begin
        ea = word_of(m_st, m_phase - 1);
        eb = word_of(m_key, m_phase - 1);
      end
      check("xor_a", xor_a, ea);
      check("xor_b", xor_b, eb);
      if (done) begin
        n_done++;
        if (sb_q.size() == 0) begin
          check("sb_nonempty_on_done", 1'b0, 1'b1);
        end else begin
          eres = sb_q.pop_front();
          check("sb_state_out", state_out, eres);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one op and waits (bounded) for done; returns to posedge+1 alignment.
  task automatic run_op(input logic [127:0] s, input logic [127:0] k,
                        output logic [127:0] res, output int lat);
    state_in = s;
    key_in   = k;
    start    = 1'b1;
    step();
    start = 1'b0;
    lat   = 0;
    res   = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin
        res = state_out;
        break;
      end
    end
    step();
  endtask

  typedef struct {
    logic [127:0] st;
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  vec_t         tbl[5];
  logic [31:0]  a_w[4];
  logic [31:0]  b_w[4];
  logic [127:0] res;
  logic [127:0] fips_st, fips_key, fips_exp, a5;
  int           lat;
  int           d0;
  int           acc0;
  int           cyc;

  initial begin
    fips_st  = 128'h00112233445566778899aabbccddeeff;
    fips_key = 128'h000102030405060708090a0b0c0d0e0f;
    fips_exp = 128'h00102030405060708090a0b0c0d0e0f0;
    a5       = {16{8'ha5}};
    tbl[0] = '{fips_st, fips_key, fips_exp};
    tbl[1] = '{a5, a5, 128'h0};
    tbl[2] = '{128'h0, {16{8'hff}}, {16{8'hff}}};
    tbl[3] = '{128'hffffffff00000000ffffffff00000000, 128'h0000ffff0000ffff0000ffff0000ffff,
               128'hffff00000000ffffffff00000000ffff};
    tbl[4] = '{128'h0123456789abcdeffedcba9876543210, {16{8'h0f}},
               128'h0e2c4a6886a4c2e0f1d3b597795b3d1f};
    a_w = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    b_w = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};

    rst_n    = 1'b0;
    start    = 1'b0;
    state_in = fips_st;
    key_in   = fips_key;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_state_out", state_out, 128'h0);
    check("rst_xor_a", xor_a, 32'h0);
    check("rst_xor_b", xor_b, 32'h0);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // Table vectors: result, latency, and hold after done.
    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].st, tbl[i].key, res, lat);
      check($sformatf("tbl%0d_result", i), res, tbl[i].exp);
      check($sformatf("tbl%0d_latency", i), lat, NW + 1);
      repeat (3) step();
      check($sformatf("tbl%0d_hold", i), state_out, tbl[i].exp);
    end

    // Operand order and result clear at start.
    state_in = fips_st;
    key_in   = fips_key;
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      if (i == 0) check("clear_on_start", state_out, 128'h0);
      check($sformatf("op_a%0d", i), xor_a, a_w[i]);
      check($sformatf("op_b%0d", i), xor_b, b_w[i]);
    end
    @(negedge clk);
    check("op_done", done, 1'b1);
    check("op_result", state_out, fips_exp);
    step();
    step();

    // Start pulsed mid-RUN with a different key is ignored.
    d0 = n_done;
    state_in = fips_st;
    key_in   = fips_key;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    key_in = {16{8'hff}};
    start  = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    check("ignore_result", state_out, fips_exp);
    check("ignore_done_count", n_done - d0, 1);

    // Reset during RUN word 2 aborts without done.
    d0 = n_done;
    state_in = fips_st;
    key_in   = fips_key;
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_state_out", state_out, 128'h0);
    step();
    step();
    rst_n = 1'b1;
    repeat (8) step();
    check("abort_no_done", n_done - d0, 0);
    run_op(a5, a5, res, lat);
    check("post_abort_result", res, 128'h0);
    check("post_abort_latency", lat, NW + 1);

    // Start held high for 20 cycles with alternating inputs.
    d0 = n_done;
    for (int i = 0; i < 20; i++) begin
      state_in = (i % 2 == 0) ? fips_st : tbl[4].st;
      key_in   = (i % 2 == 0) ? fips_key : tbl[4].key;
      start    = 1'b1;
      step();
    end
    start = 1'b0;
    repeat (10) step();
    check("held_done_count", n_done - d0, 4);
    check("held_sb_drained", sb_q.size(), 0);

    // Random ops with random gaps and back-to-back bursts.
    acc0 = m_acc;
    cyc  = 0;
    while ((m_acc - acc0) < 1000 && cyc < 30000) begin
      state_in = {$urandom, $urandom, $urandom, $urandom};
      key_in   = {$urandom, $urandom, $urandom, $urandom};
      if ((cyc / 64) % 3 == 0) start = 1'b1;
      else start = ($urandom_range(0, 2) == 0);
      step();
      cyc++;
    end
    start = 1'b0;
    repeat (10) step();
    check("rand_ops", m_acc - acc0 >= 1000, 1'b1);
    check("rand_sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
